// File: rtl/neander_loader_pkg.sv
// Shared definitions for the Neander program loader.
// Contents: host opcode bytes, response bytes, loader FSM state type.
package neander_loader_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L' addr cnt data...
  localparam logic [7:0] CMD_DUMP = 8'h44;  // 'D' addr cnt
  localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R' release CPU
  localparam logic [7:0] CMD_HALT = 8'h48;  // 'H' hold CPU

  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_CNT,
    ST_LOAD,
    ST_DUMP,
    ST_RESP
  } state_t;

endpackage

// File: rtl/neander_prog_loader.sv
// Byte-stream program loader / memory monitor for the Neander CPU.
// Parses host commands (L/D/R/H), writes RAM through the load port, dumps
// RAM through the asynchronous read port and gates the CPU reset.
// Ports:
//   clk, reset          clock, async active-high reset
//   in_valid/in_data/in_ready     host byte in (valid/ready)
//   out_valid/out_data/out_ready  response byte out (valid/ready)
//   mem_load_en/addr/data         one-cycle RAM write strobe
//   mem_read_addr/mem_read_data   RAM read-back (combinational RAM read)
//   cpu_hold            1 = CPU held in reset
//   busy                FSM not idle
module neander_prog_loader
  import neander_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       mem_load_en,
  output logic [7:0] mem_load_addr,
  output logic [7:0] mem_load_data,
  output logic [7:0] mem_read_addr,
  input  logic [7:0] mem_read_data,
  output logic       cpu_hold,
  output logic       busy
);

  state_t      r_state;
  state_t      w_next_state;

  logic        r_live;       // low only in the first cycle after reset
  logic [7:0]  r_addr;       // running RAM address for both load and dump
  logic [8:0]  r_cnt;        // bytes remaining; 9 bits so cnt=0 means 256
  logic        r_is_dump;
  logic [31:0] r_idle;
  logic        r_out_valid;
  logic [7:0]  r_out_data;
  logic        r_load_en;
  logic [7:0]  r_load_addr;
  logic [7:0]  r_load_data;
  logic        r_cpu_hold;

  logic        w_in_ready;
  logic        w_in_fire;
  logic        w_out_fire;
  logic        w_timed;
  logic        w_timeout;
  logic        w_enter_resp;
  logic [7:0]  w_rsp_data;

  always_comb begin
    w_in_ready = r_live && !r_load_en &&
                 ((r_state == ST_IDLE) || (r_state == ST_GET_ADDR) ||
                  (r_state == ST_GET_CNT) || (r_state == ST_LOAD));
    w_in_fire  = in_valid && w_in_ready;
    w_out_fire = r_out_valid && out_ready;
    // The write-strobe cycle is not an idle wait; it belongs to the byte
    // just accepted, so it neither counts nor times out.
    w_timed    = (r_state == ST_GET_ADDR) || (r_state == ST_GET_CNT) ||
                 ((r_state == ST_LOAD) && !r_load_en);
    w_timeout  = (TIMEOUT_CYCLES != 0) && w_timed && !in_valid &&
                 (r_idle == TIMEOUT_CYCLES - 32'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_rsp_data   = RSP_ACK;
    case (r_state)
      ST_IDLE: begin
        if (w_in_fire) begin
          case (in_data)
            CMD_LOAD, CMD_DUMP: begin
              if (r_cpu_hold) begin
                w_next_state = ST_GET_ADDR;
              end else begin
                // Refused while the CPU runs; operands are not consumed.
                w_next_state = ST_RESP;
                w_rsp_data   = RSP_NAK;
              end
            end
            CMD_RUN, CMD_HALT: w_next_state = ST_RESP;
            default: begin
              w_next_state = ST_RESP;
              w_rsp_data   = RSP_NAK;
            end
          endcase
        end
      end
      ST_GET_ADDR: begin
        if (w_in_fire)      w_next_state = ST_GET_CNT;
        else if (w_timeout) w_next_state = ST_IDLE;
      end
      ST_GET_CNT: begin
        if (w_in_fire)      w_next_state = r_is_dump ? ST_DUMP : ST_LOAD;
        else if (w_timeout) w_next_state = ST_IDLE;
      end
      ST_LOAD: begin
        // Finish only after the last strobe has been presented.
        if (r_load_en && (r_cnt == 9'd0)) w_next_state = ST_RESP;
        else if (w_timeout)               w_next_state = ST_IDLE;
      end
      ST_DUMP: begin
        if (w_out_fire && (r_cnt == 9'd1)) w_next_state = ST_RESP;
      end
      ST_RESP: begin
        if (w_out_fire) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
    w_enter_resp = (w_next_state == ST_RESP) && (r_state != ST_RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_live      <= 1'b0;
      r_addr      <= 8'd0;
      r_cnt       <= 9'd0;
      r_is_dump   <= 1'b0;
      r_idle      <= 32'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'd0;
      r_load_en   <= 1'b0;
      r_load_addr <= 8'd0;
      r_load_data <= 8'd0;
      r_cpu_hold  <= 1'b1;
    end else begin
      r_live    <= 1'b1;
      r_load_en <= 1'b0;
      r_idle    <= (w_timed && !in_valid) ? r_idle + 32'd1 : 32'd0;

      case (r_state)
        ST_IDLE: begin
          if (w_in_fire) begin
            r_is_dump <= (in_data == CMD_DUMP);
            if (in_data == CMD_RUN)  r_cpu_hold <= 1'b0;
            if (in_data == CMD_HALT) r_cpu_hold <= 1'b1;
          end
        end
        ST_GET_ADDR: begin
          if (w_in_fire) r_addr <= in_data;
        end
        ST_GET_CNT: begin
          // A zero count byte selects the full 256-byte page.
          if (w_in_fire) r_cnt <= {(in_data == 8'd0), in_data};
        end
        ST_LOAD: begin
          if (w_in_fire) begin
            r_load_en   <= 1'b1;
            r_load_addr <= r_addr;
            r_load_data <= in_data;
            r_addr      <= r_addr + 8'd1;
            r_cnt       <= r_cnt - 9'd1;
          end
        end
        ST_DUMP: begin
          // Alternate: capture the RAM byte, then hold it until consumed.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= mem_read_data;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_addr      <= r_addr + 8'd1;
            r_cnt       <= r_cnt - 9'd1;
          end
        end
        ST_RESP: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase

      if (w_enter_resp) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_rsp_data;
      end
    end
  end

  assign in_ready      = w_in_ready;
  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign mem_load_en   = r_load_en;
  assign mem_load_addr = r_load_addr;
  assign mem_load_data = r_load_data;
  assign mem_read_addr = r_addr;
  assign cpu_hold      = r_cpu_hold;
  assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_neander_prog_loader.sv
module tb_neander_prog_loader;
  import neander_loader_pkg::*;

  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       mem_load_en;
  logic [7:0] mem_load_addr;
  logic [7:0] mem_load_data;
  logic [7:0] mem_read_addr;
  logic [7:0] mem_read_data;
  logic       cpu_hold;
  logic       busy;

  neander_prog_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .mem_load_en(mem_load_en), .mem_load_addr(mem_load_addr),
    .mem_load_data(mem_load_data), .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data), .cpu_hold(cpu_hold), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM beside the loader; preset to a known pattern before any strobe.
  logic [7:0] ram [256];
  bit         ram_ready;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 37 + 5);
      ram_ready <= 1'b1;
    end else if (mem_load_en) begin
      ram[mem_load_addr] <= mem_load_data;
    end
  end
  assign mem_read_data = ram[mem_read_addr];

  // Reference model state
  logic [7:0]  ram_m [256];
  bit          m_hold;
  logic [7:0]  rq[$];      // expected response bytes
  logic [15:0] wq[$];      // expected writes {addr,data}
  logic [7:0]  cmd[$];

  int n_chk, n_pass, n_strobe;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Monitor / scoreboard
  logic       pv, pr, ple;
  logic [7:0] pd;
  initial begin
    pv = 0; pr = 0; pd = 0; ple = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (pv && !pr) begin
          chk("out_hold_valid", {31'd0, out_valid}, 32'd1);
          if (out_valid) chk("out_hold_data", {24'd0, out_data}, {24'd0, pd});
        end
        if (out_valid && out_ready) begin
          if (rq.size() == 0) fail_now($sformatf("unexpected_rsp %0h", out_data));
          else chk("rsp", {24'd0, out_data}, {24'd0, rq.pop_front()});
        end
        if (mem_load_en) begin
          n_strobe++;
          if (ple) fail_now("strobe_longer_than_one_cycle");
          if (wq.size() == 0) fail_now($sformatf("unexpected_write %0h=%0h", mem_load_addr, mem_load_data));
          else chk("write", {16'd0, mem_load_addr, mem_load_data}, {16'd0, wq.pop_front()});
        end
        if (out_valid && in_ready) fail_now("in_ready_during_out_valid");
      end
      pv  = out_valid && !reset;
      pr  = out_ready;
      pd  = out_data;
      ple = mem_load_en;
    end
  end

  initial begin
    out_ready = 0;
    forever begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bit ok = 0;
    in_data  = b;
    in_valid = 1;
    while (!ok) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      else begin
        n++;
        if (n > 2000) begin
          fail_now("in_ready_wait");
          in_valid = 0;
          return;
        end
      end
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n = 0;
    while (!(rq.size() == 0 && wq.size() == 0 && !busy && !out_valid)) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin fail_now("drain_timeout"); break; end
    end
    @(posedge clk); #1;
    chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, m_hold});
  endtask

  // Model: one command's expected effects from the command rules, then drive it.
  task automatic run_cmd();
    logic [7:0] a;
    int n;
    if (cmd.size() > 0) begin
      case (cmd[0])
        CMD_LOAD: if (m_hold) begin
          a = cmd[1];
          n = (cmd[2] == 0) ? 256 : int'(cmd[2]);
          for (int i = 0; i < n; i++) begin
            wq.push_back({8'(a + i), cmd[3 + i]});
            ram_m[8'(a + i)] = cmd[3 + i];
          end
          rq.push_back(RSP_ACK);
        end else rq.push_back(RSP_NAK);
        CMD_DUMP: if (m_hold) begin
          a = cmd[1];
          n = (cmd[2] == 0) ? 256 : int'(cmd[2]);
          for (int i = 0; i < n; i++) rq.push_back(ram_m[8'(a + i)]);
          rq.push_back(RSP_ACK);
        end else rq.push_back(RSP_NAK);
        CMD_RUN:  begin m_hold = 0; rq.push_back(RSP_ACK); end
        CMD_HALT: begin m_hold = 1; rq.push_back(RSP_ACK); end
        default:  rq.push_back(RSP_NAK);
      endcase
    end
    foreach (cmd[i]) begin
      send_byte(cmd[i]);
      gap();
    end
    drain();
  endtask

  task automatic run_vec(input logic [63:0] v, input int n);
    cmd.delete();
    for (int i = 0; i < n; i++) cmd.push_back(v[8*(n-1-i) +: 8]);
    run_cmd();
  endtask

  initial begin
    int s0;
    logic [7:0] keep, keep2, op;
    reset = 1; in_valid = 0; in_data = 0;
    m_hold = 1;
    for (int i = 0; i < 256; i++) ram_m[i] = 8'(i * 37 + 5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  {31'd0, in_ready},    32'd0);
    chk("rst_out_valid", {31'd0, out_valid},   32'd0);
    chk("rst_out_data",  {24'd0, out_data},    32'd0);
    chk("rst_load_en",   {31'd0, mem_load_en}, 32'd0);
    chk("rst_load_addr", {24'd0, mem_load_addr}, 32'd0);
    chk("rst_load_data", {24'd0, mem_load_data}, 32'd0);
    chk("rst_read_addr", {24'd0, mem_read_addr}, 32'd0);
    chk("rst_cpu_hold",  {31'd0, cpu_hold},    32'd1);
    chk("rst_busy",      {31'd0, busy},        32'd0);
    reset = 0;
    #1 chk("in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("in_ready_after_edge", {31'd0, in_ready}, 32'd1);

    // Basic load
    s0 = n_strobe;
    run_vec(64'h4C_80_03_11_22_33, 6);
    chk("load_strobes", n_strobe - s0, 3);
    chk("ram80", {24'd0, ram[8'h80]}, 32'h11);
    chk("ram81", {24'd0, ram[8'h81]}, 32'h22);
    chk("ram82", {24'd0, ram[8'h82]}, 32'h33);

    // Dump with backpressure (out_ready toggles randomly)
    rq.push_back(8'h11); rq.push_back(8'h22); rq.push_back(8'h33); rq.push_back(RSP_ACK);
    cmd.delete(); cmd.push_back(8'h44); cmd.push_back(8'h80); cmd.push_back(8'h03);
    foreach (cmd[i]) send_byte(cmd[i]);
    drain();

    // Address wrap
    run_vec(64'h4C_FF_02_AA_BB, 5);
    chk("ramFF", {24'd0, ram[8'hFF]}, 32'hAA);
    chk("ram00", {24'd0, ram[8'h00]}, 32'hBB);

    // Full-page load, then full-page dump
    s0 = n_strobe;
    cmd.delete(); cmd.push_back(CMD_LOAD); cmd.push_back(8'h00); cmd.push_back(8'h00);
    for (int i = 0; i < 256; i++) cmd.push_back(8'($urandom));
    run_cmd();
    chk("full_strobes", n_strobe - s0, 256);
    run_vec(64'h44_00_00, 3);

    // Run/halt gating
    run_vec(64'h52, 1);
    keep = ram[8'h10];
    run_vec(64'h4C, 1);
    run_vec(64'h10, 1);
    run_vec(64'h01, 1);
    run_vec(64'h55, 1);
    chk("ram10_untouched", {24'd0, ram[8'h10]}, {24'd0, keep});
    run_vec(64'h48, 1);

    // Unknown opcode
    run_vec(64'h7A, 1);

    // Inter-byte timeout: no response, back to idle after TO idle cycles
    send_byte(CMD_LOAD);
    send_byte(8'h10);
    repeat (TO - 1) @(posedge clk);
    @(negedge clk);
    chk("busy_before_timeout", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("busy_after_timeout", {31'd0, busy}, 32'd0);
    chk("no_rsp_after_timeout", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    run_vec(64'h52, 1);
    run_vec(64'h48, 1);

    // Reset in the middle of a load
    keep2 = ram[8'h21];
    wq.push_back({8'h20, 8'hAA});
    ram_m[8'h20] = 8'hAA;
    send_byte(CMD_LOAD); send_byte(8'h20); send_byte(8'h02); send_byte(8'hAA);
    @(posedge clk); #1;
    reset = 1;
    #1;
    chk("mid_rst_cpu_hold",  {31'd0, cpu_hold},  32'd1);
    chk("mid_rst_busy",      {31'd0, busy},      32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(posedge clk); #1;
    chk("ram20", {24'd0, ram[8'h20]}, 32'hAA);
    chk("ram21_untouched", {24'd0, ram[8'h21]}, {24'd0, keep2});
    chk("wq_after_reset", wq.size(), 0);

    // Randomized command mix
    for (int k = 0; k < 40; k++) begin
      int sel, n;
      sel = $urandom_range(0, 9);
      cmd.delete();
      if (sel <= 3) begin
        cmd.push_back(CMD_LOAD);
        if (m_hold) begin
          n = $urandom_range(1, 6);
          cmd.push_back(8'($urandom)); cmd.push_back(8'(n));
          for (int i = 0; i < n; i++) cmd.push_back(8'($urandom));
        end
      end else if (sel <= 6) begin
        cmd.push_back(CMD_DUMP);
        if (m_hold) begin
          cmd.push_back(8'($urandom)); cmd.push_back(8'($urandom_range(1, 6)));
        end
      end else if (sel == 7) cmd.push_back(CMD_RUN);
      else if (sel == 8) cmd.push_back(CMD_HALT);
      else begin
        do op = 8'($urandom);
        while (op == CMD_LOAD || op == CMD_DUMP || op == CMD_RUN || op == CMD_HALT);
        cmd.push_back(op);
      end
      run_cmd();
    end

    for (int i = 0; i < 256; i++)
      if (ram[i] !== ram_m[i]) fail_now($sformatf("ram[%0h] got %0h expected %0h", i, ram[i], ram_m[i]));
    chk("rq_empty", rq.size(), 0);
    chk("wq_empty", wq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
